alu_wb_buffer: RTL and testbench

Writeback buffer downstream of the 32-bit ALU (`Bit32_alu`). It captures each ALU result, together with its opcode and the neg/carry/overflow/zero flags, into a DEPTH-entry FIFO with valid/ready handshakes on both sides. It also keeps sticky status flags and a saturating signed-overflow event counter for the control/debug path. The register-file writeback or a trace consumer drains the FIFO.

---
 rtl/alu_pkg.sv | 28 ++
 rtl/alu_wb_fifo_mem.sv | 25 ++
 rtl/alu_wb_buffer.sv | 124 ++++++++++++
 tb/tb_alu_wb_buffer.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared ALU definitions: flag bit positions, opcodes and the writeback entry layout.
package alu_pkg;

  localparam int ALU_W = 32;

  // Bit positions inside the 4-bit flag vector {neg, carry, overflow, zero}
  localparam int FLAG_NEG   = 3;
  localparam int FLAG_CARRY = 2;
  localparam int FLAG_OVF   = 1;
  localparam int FLAG_ZERO  = 0;

  localparam logic [3:0] OP_ADD = 4'b0000;
  localparam logic [3:0] OP_SUB = 4'b0001;
  localparam logic [3:0] OP_AND = 4'b0010;
  localparam logic [3:0] OP_OR  = 4'b0011;
  localparam logic [3:0] OP_XOR = 4'b0100;
  localparam logic [3:0] OP_SLL = 4'b0101;
  localparam logic [3:0] OP_SRL = 4'b0110;
  localparam logic [3:0] OP_SRA = 4'b0111;
  localparam logic [3:0] OP_SLT = 4'b1000;

  typedef struct packed {
    logic [3:0]       con;
    logic [3:0]       flags;
    logic [ALU_W-1:0] res;
  } wb_entry_t;

endpackage

// File: rtl/alu_wb_fifo_mem.sv
// DEPTH x WIDTH register array, one write port and one asynchronous read port.
module alu_wb_fifo_mem #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 40
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  logic [WIDTH-1:0]         wdata,
  input  logic [$clog2(DEPTH)-1:0] raddr,
  output logic [WIDTH-1:0]         rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  // Storage write; contents are don't-care until written, so no reset
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/alu_wb_buffer.sv
// Writeback FIFO for ALU results with sticky flag status and a saturating overflow counter.
module alu_wb_buffer
  import alu_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 4,
  parameter int CNT_W  = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [DATA_W-1:0]        in_res,
  input  logic [3:0]               in_con,
  input  logic                     in_neg,
  input  logic                     in_carry,
  input  logic                     in_overflow,
  input  logic                     in_zero,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [DATA_W-1:0]        out_res,
  output logic [3:0]               out_con,
  output logic [3:0]               out_flags,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty,
  output logic [3:0]               sticky_flags,
  input  logic                     sticky_clr,
  output logic [CNT_W-1:0]         ovf_cnt
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int OCC_W = PTR_W + 1;
  localparam int ENT_W = DATA_W + 8;

  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             push;
  logic             pop;
  logic [3:0]       in_flags;
  logic [ENT_W-1:0] wr_entry;
  logic [ENT_W-1:0] rd_entry;

  assign full      = (count == OCC_W'(DEPTH));
  assign empty     = (count == {OCC_W{1'b0}});
  assign in_ready  = !full;
  assign out_valid = !empty;
  assign push      = in_valid && !full;
  assign pop       = !empty && out_ready;

  // Pack incoming flags by their package bit positions
  always_comb begin
    in_flags            = 4'b0000;
    in_flags[FLAG_NEG]   = in_neg;
    in_flags[FLAG_CARRY] = in_carry;
    in_flags[FLAG_OVF]   = in_overflow;
    in_flags[FLAG_ZERO]  = in_zero;
  end

  assign wr_entry = {in_con, in_flags, in_res};

  alu_wb_fifo_mem #(
    .DEPTH (DEPTH),
    .WIDTH (ENT_W)
  ) u_mem (
    .clk   (clk),
    .we    (push),
    .waddr (wr_ptr),
    .wdata (wr_entry),
    .raddr (rd_ptr),
    .rdata (rd_entry)
  );

  // Pointers and occupancy
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= {PTR_W{1'b0}};
      rd_ptr <= {PTR_W{1'b0}};
      count  <= {OCC_W{1'b0}};
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + OCC_W'(1);
        2'b01:   count <= count - OCC_W'(1);
        default: count <= count;
      endcase
    end
  end

  // Sticky flags: flags pushed in a clear cycle survive the clear
  always_ff @(posedge clk) begin
    if (rst) begin
      sticky_flags <= 4'b0000;
    end else begin
      sticky_flags <= (sticky_clr ? 4'b0000 : sticky_flags) | (push ? in_flags : 4'b0000);
    end
  end

  // Saturating count of accepted overflow results
  always_ff @(posedge clk) begin
    if (rst) begin
      ovf_cnt <= {CNT_W{1'b0}};
    end else if (push && in_overflow && (ovf_cnt != {CNT_W{1'b1}})) begin
      ovf_cnt <= ovf_cnt + CNT_W'(1);
    end else begin
      ovf_cnt <= ovf_cnt;
    end
  end

  // Head view, zeroed while empty so stale storage never leaks out
  always_comb begin
    if (empty) begin
      out_res   = {DATA_W{1'b0}};
      out_con   = 4'b0000;
      out_flags = 4'b0000;
    end else begin
      out_res   = rd_entry[DATA_W-1:0];
      out_flags = rd_entry[DATA_W+3:DATA_W];
      out_con   = rd_entry[DATA_W+7:DATA_W+4];
    end
  end

endmodule

// File: tb/tb_alu_wb_buffer.sv
// Directed self-checking bench for alu_wb_buffer with hand-computed expectations.
module tb_alu_wb_buffer;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_res;
  logic [3:0]  in_con;
  logic        in_neg, in_carry, in_overflow, in_zero;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_res;
  logic [3:0]  out_con;
  logic [3:0]  out_flags;
  logic [2:0]  count;
  logic        full, empty;
  logic [3:0]  sticky_flags;
  logic        sticky_clr;
  logic [7:0]  ovf_cnt;

  int n_tests = 0;
  int n_fail  = 0;

  alu_wb_buffer #(.DATA_W(32), .DEPTH(4), .CNT_W(8)) dut (
    .clk          (clk),
    .rst          (rst),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_res       (in_res),
    .in_con       (in_con),
    .in_neg       (in_neg),
    .in_carry     (in_carry),
    .in_overflow  (in_overflow),
    .in_zero      (in_zero),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_res      (out_res),
    .out_con      (out_con),
    .out_flags    (out_flags),
    .count        (count),
    .full         (full),
    .empty        (empty),
    .sticky_flags (sticky_flags),
    .sticky_clr   (sticky_clr),
    .ovf_cnt      (ovf_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance one edge and settle away from it
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] r, input logic [3:0] c, input logic [3:0] f);
    in_valid    = v;
    in_res      = r;
    in_con      = c;
    in_neg      = f[3];
    in_carry    = f[2];
    in_overflow = f[1];
    in_zero     = f[0];
  endtask

  initial begin
    rst = 1'b1; out_ready = 1'b0; sticky_clr = 1'b0;
    drive(1'b0, 32'h0, 4'h0, 4'h0);
    step(); step();
    rst = 1'b0;

    // Reset state
    check("rst_count", 64'(count), 64'd0);
    check("rst_empty", 64'(empty), 64'd1);
    check("rst_full", 64'(full), 64'd0);
    check("rst_in_ready", 64'(in_ready), 64'd1);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_out_res", 64'(out_res), 64'd0);
    check("rst_sticky", 64'(sticky_flags), 64'd0);
    check("rst_ovf_cnt", 64'(ovf_cnt), 64'd0);

    // Single push, visible after the edge
    drive(1'b1, 32'h00000008, 4'b0000, 4'b0000);
    step();
    drive(1'b0, 32'h0, 4'h0, 4'h0);
    check("one_out_valid", 64'(out_valid), 64'd1);
    check("one_out_res", 64'(out_res), 64'h8);
    check("one_count", 64'(count), 64'd1);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    check("one_empty", 64'(empty), 64'd1);

    // Fill to DEPTH, refuse a fifth push, drain in order
    for (int i = 1; i <= 4; i++) begin
      drive(1'b1, 32'(i), 4'(i), 4'b0000);
      step();
    end
    check("fill_full", 64'(full), 64'd1);
    check("fill_in_ready", 64'(in_ready), 64'd0);
    check("fill_count", 64'(count), 64'd4);
    drive(1'b1, 32'd5, 4'd5, 4'b0000);
    step();
    drive(1'b0, 32'h0, 4'h0, 4'h0);
    check("refuse_count", 64'(count), 64'd4);
    check("refuse_head", 64'(out_res), 64'd1);
    out_ready = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      check($sformatf("drain_res%0d", i), 64'(out_res), 64'(i));
      check($sformatf("drain_con%0d", i), 64'(out_con), 64'(i));
      step();
    end
    out_ready = 1'b0;
    check("drain_empty", 64'(empty), 64'd1);
    check("drain_out_res_zero", 64'(out_res), 64'd0);

    // Overflowing add: neg=1 ovf=1 -> 1010
    drive(1'b1, 32'hFFFFFFFE, 4'b0000, 4'b1010);
    step();
    check("ovf_sticky", 64'(sticky_flags), 64'b1010);
    check("ovf_cnt_one", 64'(ovf_cnt), 64'd1);
    check("ovf_out_flags", 64'(out_flags), 64'b1010);
    drive(1'b1, 32'h0, 4'b0001, 4'b0001);
    sticky_clr = 1'b1;
    step();
    sticky_clr = 1'b0;
    drive(1'b0, 32'h0, 4'h0, 4'h0);
    check("clr_push_sticky", 64'(sticky_flags), 64'b0001);
    check("clr_ovf_cnt", 64'(ovf_cnt), 64'd1);
    out_ready = 1'b1;
    step(); step();
    check("ovf_drain_empty", 64'(empty), 64'd1);

    // Streaming: one push and one pop per cycle, no bubbles
    for (int k = 0; k < 12; k++) begin
      drive(1'b1, 32'(100 + k), 4'(k), 4'b0000);
      step();
      check($sformatf("stream_valid%0d", k), 64'(out_valid), 64'd1);
      check($sformatf("stream_res%0d", k), 64'(out_res), 64'(100 + k));
      check($sformatf("stream_con%0d", k), 64'(out_con), 64'(k[3:0]));
      check($sformatf("stream_count%0d", k), 64'(count), 64'd1);
    end
    drive(1'b0, 32'h0, 4'h0, 4'h0);
    step();
    check("stream_empty", 64'(empty), 64'd1);

    // Overflow counter saturation (already at 1)
    for (int k = 0; k < 260; k++) begin
      drive(1'b1, 32'(k), 4'b0000, 4'b0010);
      step();
      if (k == 252) check("sat_pre", 64'(ovf_cnt), 64'd254);
    end
    drive(1'b0, 32'h0, 4'h0, 4'h0);
    step();
    check("sat_ovf_cnt", 64'(ovf_cnt), 64'hFF);
    out_ready = 1'b0;

    // Reset mid-operation with three entries queued
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 32'hA0 + 32'(i), 4'b0011, 4'b0100);
      step();
    end
    check("pre_rst_count", 64'(count), 64'd3);
    rst = 1'b1; sticky_clr = 1'b0;
    drive(1'b1, 32'hDEAD, 4'hF, 4'b1111);
    step();
    rst = 1'b0;
    drive(1'b0, 32'h0, 4'h0, 4'h0);
    check("mrst_count", 64'(count), 64'd0);
    check("mrst_out_valid", 64'(out_valid), 64'd0);
    check("mrst_out_res", 64'(out_res), 64'd0);
    check("mrst_out_con", 64'(out_con), 64'd0);
    check("mrst_out_flags", 64'(out_flags), 64'd0);
    check("mrst_sticky", 64'(sticky_flags), 64'd0);
    check("mrst_ovf_cnt", 64'(ovf_cnt), 64'd0);
    check("mrst_in_ready", 64'(in_ready), 64'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
